flit_link_tx: RTL

- Transmit end of the inter-router link; the downstream receive end reassembles words into the 55-bit input buffer.
- Accepts one 55-bit flit from the local output buffer, waits until this router holds the ring token, then sends the flit as PHIT_W-bit phits under a valid/ready handshake.
- Returns the token with a one-cycle pulse after the last phit is accepted.

---
 rtl/flit_link_tx.sv | 94 +++++++++
 1 files changed

// File: rtl/flit_link_tx.sv
// Link transmit end: captures one flit, waits for the ring token, serialises the
// flit into phits LSB-first under valid/ready, then returns the token with a pulse.
module flit_link_tx #(
  parameter int unsigned WORD_W = 55,
  parameter int unsigned PHIT_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              token_in,
  output logic              token_release,
  output logic [PHIT_W-1:0] phit_out,
  output logic              phit_valid,
  output logic              phit_last,
  input  logic              phit_ready,
  output logic              busy
);

  localparam int unsigned NPHIT = WORD_W / PHIT_W;
  localparam int unsigned CNT_W = (NPHIT > 1) ? $clog2(NPHIT) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_TOKEN = 2'd1,
    SEND       = 2'd2,
    RELEASE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_c;

  assign last_c = (cnt_q == CNT_W'(NPHIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: token is only looked at while waiting; SEND runs to completion.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = WAIT_TOKEN;
        end
      end
      WAIT_TOKEN: begin
        if (token_in) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (phit_ready) begin
          shreg_d = shreg_q >> PHIT_W;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_c) begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign phit_valid    = (state_q == SEND);
  assign phit_last     = phit_valid && last_c;
  assign phit_out      = phit_valid ? shreg_q[PHIT_W-1:0] : '0;
  assign token_release = (state_q == RELEASE);

endmodule
